// File: rtl/ram64_burst_master_if.sv
// Bundles the command, write-stream, read-stream, status and Ram64-side signals
// of the burst master; the master modport is the controller's view.
interface ram64_burst_master_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] cmd_len;

   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;

   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;

   logic              busy;
   logic              done;

   logic [DATA_W-1:0] ram_in;
   logic              ram_load;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_out;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  wr_data, wr_valid, rd_ready, ram_out,
      output cmd_ready, wr_ready, rd_data, rd_valid,
      output busy, done, ram_in, ram_load, ram_address
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      output wr_data, wr_valid, rd_ready, ram_out,
      input  cmd_ready, wr_ready, rd_data, rd_valid,
      input  busy, done, ram_in, ram_load, ram_address
   );
endinterface

// File: rtl/ram64_burst_master.sv
// Burst controller for a 64-word Ram64: streams write beats straight into the RAM
// and reads bursts back through a one-entry registered output stage.
module ram64_burst_master #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
) (
   input logic                  clock,
   input logic                  reset_n,
   ram64_burst_master_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] count;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   logic              cmd_take;
   logic              wr_beat;
   logic              rd_cap;
   logic              rd_take;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The read stage refills whenever it is empty or being emptied, so a held
   // rd_ready sustains one beat per cycle.
   always_comb begin
      state_next = state;
      cmd_take   = 1'b0;
      wr_beat    = 1'b0;
      rd_cap     = 1'b0;
      rd_take    = 1'b0;
      case (state)
         IDLE: begin
            cmd_take = bus.cmd_valid;
            if (cmd_take) begin
               state_next = bus.cmd_write ? WRITE : READ;
            end
         end
         WRITE: begin
            wr_beat = bus.wr_valid;
            if (wr_beat && count == '0) begin
               state_next = DONE;
            end
         end
         READ: begin
            rd_cap = !rd_valid_q || bus.rd_ready;
            if (rd_cap && count == '0) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            rd_take = rd_valid_q && bus.rd_ready;
            if (rd_take) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr        <= '0;
         count      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         if (cmd_take) begin
            ptr   <= bus.cmd_addr;
            count <= bus.cmd_len;
         end else if (wr_beat || rd_cap) begin
            ptr   <= ptr + 1'b1;
            count <= count - 1'b1;
         end
         if (rd_cap) begin
            rd_data_q  <= bus.ram_out;
            rd_valid_q <= 1'b1;
         end else if (rd_take) begin
            rd_valid_q <= 1'b0;
         end
      end
   end

   // ram_load is purely combinational on state, so an asserted reset kills it at once.
   assign bus.cmd_ready   = (state == IDLE);
   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == DONE);
   assign bus.wr_ready    = (state == WRITE);
   assign bus.ram_load    = wr_beat;
   assign bus.ram_in      = bus.wr_data;
   assign bus.ram_address = ptr;
   assign bus.rd_data     = rd_data_q;
   assign bus.rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_ram64_burst_master.sv
// Randomized bench for ram64_burst_master: a behavioural Ram64 sits on the RAM port
// and an array model of expected memory contents checks writes and read streams.
module tb_ram64_burst_master;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   ram64_burst_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   ram64_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   logic [DATA_W-1:0] ram   [DEPTH];
   logic [DATA_W-1:0] model [DEPTH];
   logic [DATA_W-1:0] wdata [DEPTH];

   always @(posedge clock) begin
      if (bus.ram_load) ram[bus.ram_address] <= bus.ram_in;
   end
   assign bus.ram_out = ram[bus.ram_address];

   int compared   = 0;
   int mismatched = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkMemory(input string tag);
      for (int i = 0; i < DEPTH; i++) checkOutput(tag, ram[i], model[i]);
   endtask

   task automatic fillData(input int base, input bit random_data);
      for (int i = 0; i < DEPTH; i++) begin
         wdata[i] = random_data ? DATA_W'($urandom) : DATA_W'(base + i);
      end
   endtask

   // gap_mode: 0 = wr_valid held high, 1 = pattern 1,0,0,..., 2 = random
   task automatic applyWrite(input int addr, input int len, input int gap_mode, input bit poke_cmd);
      int beat = 0;
      int cycles = 0;
      int run = 0;
      int max_run = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = ADDR_W'(addr);
      bus.cmd_len   = ADDR_W'(len);
      #1;
      checkOutput("cmd_ready_idle", bus.cmd_ready, 1);
      @(posedge clock); #1;
      bus.cmd_valid = poke_cmd;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = ADDR_W'($urandom);
      bus.cmd_len   = ADDR_W'($urandom);
      while (beat <= len && cycles < 1000) begin
         case (gap_mode)
            0:       bus.wr_valid = 1'b1;
            1:       bus.wr_valid = ((cycles % 3) == 0);
            default: bus.wr_valid = 1'($urandom);
         endcase
         bus.wr_data = wdata[beat];
         #1;
         checkOutput("ram_load_vs_wr_valid", bus.ram_load, bus.wr_valid);
         checkOutput("wr_ready_in_write", bus.wr_ready, 1);
         if (poke_cmd) checkOutput("cmd_ready_while_busy", bus.cmd_ready, 0);
         if (bus.wr_valid) begin
            model[(addr + beat) % DEPTH] = wdata[beat];
            beat++;
            run++;
         end else begin
            run = 0;
         end
         if (run > max_run) max_run = run;
         @(posedge clock); #1;
         cycles++;
      end
      bus.wr_valid  = 1'b0;
      bus.cmd_valid = 1'b0;
      checkOutput("write_beats", beat, len + 1);
      if (gap_mode == 0) checkOutput("write_load_run", max_run, len + 1);
      checkOutput("done_after_write", bus.done, 1);
      checkOutput("wr_ready_in_done", bus.wr_ready, 0);
      checkOutput("cmd_ready_in_done", bus.cmd_ready, 0);
      @(posedge clock); #1;
      checkOutput("done_single_cycle", bus.done, 0);
      checkOutput("idle_after_write", bus.cmd_ready, 1);
      checkOutput("ptr_after_write", bus.ram_address, (addr + len + 1) % DEPTH);
      checkMemory("ram_after_write");
   endtask

   // ready_mode: 0 = rd_ready held high, 1 = toggling, 2 = random
   task automatic applyRead(input int addr, input int len, input int ready_mode);
      int got = 0;
      int cycles = 1;
      int first_valid = -1;
      bit hold_pending = 1'b0;
      logic [DATA_W-1:0] held = '0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = ADDR_W'(addr);
      bus.cmd_len   = ADDR_W'(len);
      bus.rd_ready  = 1'b0;
      @(posedge clock); #1;
      bus.cmd_valid = 1'b0;
      while (got <= len && cycles < 2000) begin
         case (ready_mode)
            0:       bus.rd_ready = 1'b1;
            1:       bus.rd_ready = ((cycles % 2) == 0);
            default: bus.rd_ready = 1'($urandom);
         endcase
         #1;
         if (bus.rd_valid && first_valid < 0) first_valid = cycles;
         if (hold_pending) begin
            checkOutput("rd_valid_held", bus.rd_valid, 1);
            checkOutput("rd_data_held", bus.rd_data, held);
         end
         hold_pending = bus.rd_valid && !bus.rd_ready;
         held = bus.rd_data;
         checkOutput("wr_ready_in_read", bus.wr_ready, 0);
         if (bus.rd_valid && bus.rd_ready) begin
            checkOutput("rd_data", bus.rd_data, model[(addr + got) % DEPTH]);
            got++;
         end
         @(posedge clock); #1;
         cycles++;
      end
      bus.rd_ready = 1'b0;
      checkOutput("read_beats", got, len + 1);
      checkOutput("rd_first_latency", first_valid, 2);
      checkOutput("done_after_read", bus.done, 1);
      checkOutput("rd_valid_after_read", bus.rd_valid, 0);
      @(posedge clock); #1;
      checkOutput("done_single_cycle_rd", bus.done, 0);
      checkOutput("idle_after_read", bus.cmd_ready, 1);
      checkOutput("ptr_after_read", bus.ram_address, (addr + len + 1) % DEPTH);
   endtask

   task automatic applyStimulus();
      int addr;
      int len;
      // directed write then read of 0xA000..0xA003 at address 5
      fillData(16'hA000, 1'b0);
      applyWrite(5, 3, 0, 1'b0);
      applyRead(5, 3, 0);
      // wrap-around burst through 63 -> 0, with commands poked while busy
      fillData(0, 1'b1);
      applyWrite(62, 3, 2, 1'b1);
      applyRead(62, 3, 2);
      // full 64-word bursts, read with toggling rd_ready
      fillData(0, 1'b1);
      applyWrite(17, 63, 0, 1'b0);
      applyRead(40, 63, 1);
      // gapped write stream
      fillData(0, 1'b1);
      applyWrite(int'($urandom_range(0, 63)), int'($urandom_range(2, 12)), 1, 1'b0);

      // reset in the middle of an 8-beat write, after four beats have landed
      fillData(0, 1'b1);
      addr = int'($urandom_range(0, 63));
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = ADDR_W'(addr);
      bus.cmd_len   = ADDR_W'(7);
      @(posedge clock); #1;
      bus.cmd_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = wdata[b];
         model[(addr + b) % DEPTH] = wdata[b];
         @(posedge clock); #1;
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = wdata[4];
      #1;
      checkOutput("ram_load_before_abort", bus.ram_load, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("ram_load_on_reset", bus.ram_load, 0);
      checkOutput("wr_ready_on_reset", bus.wr_ready, 0);
      checkOutput("cmd_ready_on_reset", bus.cmd_ready, 1);
      checkOutput("busy_on_reset", bus.busy, 0);
      checkOutput("ptr_on_reset", bus.ram_address, 0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      bus.wr_valid = 1'b0;
      reset_n = 1'b1;
      checkMemory("ram_after_abort");

      // first command straight after reset release
      applyRead(int'($urandom_range(0, 63)), int'($urandom_range(0, 9)), 2);

      // reset while a read beat is pending
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = ADDR_W'($urandom);
      bus.cmd_len   = ADDR_W'(10);
      bus.rd_ready  = 1'b0;
      @(posedge clock); #1;
      bus.cmd_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clock); #1;
      end
      checkOutput("rd_pending_before_reset", bus.rd_valid, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("rd_valid_on_reset", bus.rd_valid, 0);
      checkOutput("rd_data_on_reset", bus.rd_data, 0);
      checkOutput("busy_on_read_reset", bus.busy, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // randomized bursts
      for (int n = 0; n < 6; n++) begin
         addr = int'($urandom_range(0, 63));
         len  = int'($urandom_range(0, 63));
         fillData(0, 1'b1);
         applyWrite(addr, len, int'($urandom_range(0, 2)), 1'($urandom));
         applyRead(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.wr_data   = '0;
      bus.wr_valid  = 1'b0;
      bus.rd_ready  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]   = DATA_W'($urandom);
         model[i] = ram[i];
      end
      #12;
      checkOutput("reset_cmd_ready", bus.cmd_ready, 1);
      checkOutput("reset_busy", bus.busy, 0);
      checkOutput("reset_done", bus.done, 0);
      checkOutput("reset_rd_valid", bus.rd_valid, 0);
      checkOutput("reset_rd_data", bus.rd_data, 0);
      checkOutput("reset_wr_ready", bus.wr_ready, 0);
      checkOutput("reset_ram_load", bus.ram_load, 0);
      checkOutput("reset_ptr", bus.ram_address, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      applyStimulus();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ram64_burst_master.md
RAM64_BURST_MASTER -- requirements
Module: ram64_burst_master

Interface
REQ-001 Parameter DATA_W, default 16: word width; SHALL match the Ram64 data port.
REQ-002 Parameter ADDR_W, default 6: word address width, giving a 64-word space; SHALL match the Ram64 address port.
REQ-003 Port clock, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port cmd_valid, input, 1: command offered.
REQ-006 Port cmd_ready, output, 1: command accepted when cmd_valid is also high.
REQ-007 Port cmd_write, input, 1: 1 = burst write, 0 = burst read.
REQ-008 Port cmd_addr, input, ADDR_W: start word address.
REQ-009 Port cmd_len, input, ADDR_W: beats minus 1 (0 means 1 beat, 63 means 64 beats).
REQ-010 Port wr_data, input, DATA_W: write-stream data.
REQ-011 Port wr_valid, input, 1: write beat offered.
REQ-012 Port wr_ready, output, 1: write beat accepted.
REQ-013 Port rd_data, output, DATA_W: registered read-stream data.
REQ-014 Port rd_valid, output, 1: rd_data holds a valid beat.
REQ-015 Port rd_ready, input, 1: consumer accepts the beat.
REQ-016 Port busy, output, 1: a burst is in progress.
REQ-017 Port done, output, 1: one-cycle pulse at burst completion.
REQ-018 Port ram_in, output, DATA_W: drives the Ram64 data input.
REQ-019 Port ram_load, output, 1: drives the Ram64 write enable.
REQ-020 Port ram_address, output, ADDR_W: drives the Ram64 address.
REQ-021 Port ram_out, input, DATA_W: Ram64 combinational read data for ram_address.

Function
REQ-022 States SHALL be IDLE, WRITE, READ, DRAIN, DONE. All handshakes complete on a rising edge with valid and ready both high.
REQ-023 cmd_ready SHALL equal (state==IDLE). busy SHALL equal (state!=IDLE). done SHALL equal (state==DONE).
REQ-024 On command acceptance:
- ptr register (drives ram_address) SHALL load cmd_addr.
- Beat counter SHALL load cmd_len.
- Next state SHALL be WRITE if cmd_write, else READ.
REQ-025 WRITE behaviour:
- wr_ready SHALL be 1.
- ram_in SHALL equal wr_data (combinational).
- ram_load SHALL equal wr_valid (combinational).
- Each accepted beat SHALL write wr_data to Ram64[ptr] at that edge, then increment ptr.
REQ-026 Outside WRITE, wr_ready and ram_load SHALL be 0.
REQ-027 READ behaviour: when (!rd_valid || rd_ready), the block SHALL:
- capture ram_out into rd_data;
- set rd_valid;
- increment ptr.
If that condition is false, rd_data, rd_valid and ptr SHALL hold.
REQ-028 Read throughput and latency:
- Full throughput is 1 beat per cycle while rd_ready is held high.
- First rd_valid SHALL rise 2 cycles after command acceptance.
REQ-029 rd_valid SHALL clear on a read handshake with no new capture in the same cycle.
REQ-030 Beat counting:
- Counter SHALL decrement per write beat or read capture.
- A beat taken with counter==0 is the last beat.
- Last write beat: next state SHALL be DONE.
- Last read capture: next state SHALL be DRAIN.
REQ-031 DRAIN SHALL hold until the final rd handshake, then go to DONE.
REQ-032 DONE SHALL last exactly 1 cycle and then return to IDLE. No command SHALL be accepted during DONE.
REQ-033 ptr SHALL increment modulo 64 (63 -> 0). A 64-beat burst SHALL visit every address exactly once.
REQ-034 In IDLE, ram_address SHALL hold the ptr value. ptr SHALL be one past the last accessed address after a burst.
REQ-035 Commands offered while busy SHALL be ignored, with cmd_ready=0 and no state change.

Reset
REQ-036 While reset_n=0, asynchronously:
- state SHALL be IDLE;
- ptr, counter and rd_data SHALL be 0;
- rd_valid, done, wr_ready and ram_load SHALL be 0;
- cmd_ready SHALL be 1.
REQ-037 Reset during a burst SHALL abort it immediately:
- No Ram64 write SHALL occur after reset_n falls.
- Partial data already written SHALL remain in the Ram64.
- A pending rd beat SHALL be discarded.
REQ-038 After reset_n rises, the first command SHALL be accepted on the first rising edge with cmd_valid=1.

Verification
REQ-039 Write addr=5, len=3, data 0xA000..0xA003 with wr_valid held high -> ram_load high for 4 consecutive cycles; Ram64[5..8]=0xA000..0xA003; done pulses the cycle after the last beat.
REQ-040 Read addr=5, len=3, rd_ready=1 -> rd_valid rises 2 cycles after acceptance; rd_data sequence 0xA000..0xA003 in 4 consecutive cycles; done pulses once.
REQ-041 Write addr=62, len=3 -> writes hit addresses 62, 63, 0, 1; a readback from 62 returns the same 4 words in order.
REQ-042 Read len=63 with rd_ready toggling 1,0,1,0 -> exactly 64 beats, none duplicated or dropped; rd_data stable while rd_valid=1 and rd_ready=0.
REQ-043 Write len=7 with reset_n pulled low after beat 3 -> ram_load drops immediately; addresses for beats 4..7 are unchanged; cmd_ready=1 after release.
REQ-044 Write burst with wr_valid gapped (1,0,0,1,...) -> ram_load never high without wr_valid; the burst completes only after all len+1 beats.
